regfile: RTL and testbench
==========================

Name: regfile

Overview:
- General-purpose register file for the pipelined 32-bit CPU datapath.
- 32 registers × 32 bits; two combinational read ports (A, B) and one synchronous write port (W).
- Register 0 is hardwired to zero.
- Sits in the decode stage; writeback drives the write port.

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- ADDR_W, 5, register address width; register count = 2**ADDR_W (32).

Ports:
- clk  input  1  system clock; all writes occur on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- WE  input  1  write enable, active high.
- rW  input  ADDR_W  write register address.
- rA  input  ADDR_W  read address, port A.
- rB  input  ADDR_W  read address, port B.
- W  input  DATA_W  write data.
- A  output  DATA_W  read data, port A.
- B  output  DATA_W  read data, port B.

Behaviour:
- Clocking and reset:
  - One clock (clk).
  - Reset is asynchronous and active-low (rst_n).
  - rst_n low clears all 32 registers to 32'h00000000 immediately, regardless of clk.
  - A and B therefore read 0 during reset.
- Write:
  - On the rising edge of clk, with rst_n high and WE=1, reg[rW] <= W.
  - WE=0: no register changes.
  - rW=0: the write is discarded and reg[0] stays 0 permanently.
- Read:
  - Purely combinational: A = reg[rA], B = reg[rB]. No clock latency.
  - A new written value appears on A/B after the rising edge that commits it.
  - rA=0 or rB=0 always returns 0.
- Same address on both ports: rA==rB is legal; both outputs carry the same value.
- Write/read collision (default build): if a read address equals rW in the cycle a write is pending, the output shows the OLD value until the edge, then the new value.
- Reset deassertion: asynchronous assert, with no write on the edge coincident with rst_n rising. If rst_n is low at a clk rising edge, the write is ignored.
- No X propagation: all registers are defined after reset; outputs are never X after the first reset.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined (write-through bypass):
  - When WE=1, rW!=0 and rA==rW, A = W combinationally, in the same cycle, before the edge.
  - Likewise B = W when rB==rW.
  - rW=0 is never bypassed; reading reg 0 stays 0.
  - Bypass is inactive while rst_n is low.
- Not defined: reads return stored contents only (old value until the edge), per the default Behaviour.

Test Plan:
- Write-disable: reset, then WE=0, rW=1, W=32'hFFFFFFFF, rA=1, for 12 clocks -> A stays 32'h00000000.
- Write enable: WE=1, rW=1, W=32'hFFFFFFFF, rA=1 -> A = 32'hFFFFFFFF after the next rising edge; B (rB=2) stays 0.
- Second register: WE=1, rW=2, W=32'h88888888, rB=2 -> B = 32'h88888888 after the edge; A (rA=1) still 32'hFFFFFFFF.
- R0 protection: WE=1, rW=0, W=32'h88888888, rA=0, for several edges -> A = 32'h00000000 throughout.
- Async reset: with reg1 and reg2 written, pulse rst_n low mid-cycle between edges -> A and B go to 0 immediately, without waiting for a clock edge. After release, a WE=1 write to reg3 of 32'h12345678 reads back correctly on rA=3.
- Collision:
  - Setup: reg5 = 32'h11111111; in the same cycle drive WE=1, rW=5, W=32'hAAAAAAAA, rA=rB=5.
  - Without REGFILE_BYPASS_EN: A = B = 32'h11111111 before the edge and 32'hAAAAAAAA after it.
  - With REGFILE_BYPASS_EN: A = B = 32'hAAAAAAAA before the edge.

Source files
------------

// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile -- general-purpose register file for the 32-bit pipelined CPU.
//
// 2**ADDR_W registers of DATA_W bits. Register 0 always reads as zero and
// can never be written. Two combinational read ports (A, B) and one write
// port (W) that commits on the rising edge of clk.
//
// Ports:
//   clk    in   system clock, writes commit on the rising edge
//   rst_n  in   asynchronous active-low reset, clears every register
//   WE     in   write enable
//   rW     in   write address
//   rA     in   read address, port A
//   rB     in   read address, port B
//   W      in   write data
//   A      out  read data, port A (combinational)
//   B      out  read data, port B (combinational)
//
// Build option:
//   REGFILE_BYPASS_EN  when defined, a read whose address matches a pending
//                      write (WE=1, rW!=0) returns W in the same cycle.
//                      When undefined, reads return stored contents only.
// ---------------------------------------------------------------------------
module regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              WE,
    input  logic [ADDR_W-1:0] rW,
    input  logic [ADDR_W-1:0] rA,
    input  logic [ADDR_W-1:0] rB,
    input  logic [DATA_W-1:0] W,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_reg [NREG];

    // Entry 0 is never written; the read path also masks it, so its
    // contents are irrelevant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (WE && (rW != '0)) begin
            regs_reg[rW] <= W;
        end
    end

    // Both read ports share one structure; index 0 is port A, 1 is port B.
    logic [1:0][ADDR_W-1:0] raddr;
    logic [1:0][DATA_W-1:0] rdata;

    assign raddr = {rB, rA};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [DATA_W-1:0] stored;

            assign stored = (raddr[gi] == '0) ? '0 : regs_reg[raddr[gi]];

`ifdef REGFILE_BYPASS_EN
            logic hit;

            // Forward the in-flight write so the reader does not have to
            // wait for the edge. Suppressed during reset and for reg 0.
            assign hit       = rst_n && WE && (rW != '0) && (raddr[gi] == rW);
            assign rdata[gi] = hit ? W : stored;
`else
            assign rdata[gi] = stored;
`endif
        end
    endgenerate

    assign A = rdata[0];
    assign B = rdata[1];

endmodule

// File: tb/tb_regfile.sv
module tb_regfile;

    logic        clk;
    logic        rst_n;
    logic        WE;
    logic [4:0]  rW;
    logic [4:0]  rA;
    logic [4:0]  rB;
    logic [31:0] W;
    logic [31:0] A;
    logic [31:0] B;

    int total = 0;
    int bad   = 0;

    regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .WE   (WE),
        .rW   (rW),
        .rA   (rA),
        .rB   (rB),
        .W    (W),
        .A    (A),
        .B    (B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // Step past the next rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_pre;

    initial begin
        rst_n = 1'b1;
        WE    = 1'b0;
        rW    = '0;
        rA    = '0;
        rB    = '0;
        W     = '0;

        // Reset asserted between edges: outputs read zero.
        #2 rst_n = 1'b0;
        rA = 5'd1;
        rB = 5'd2;
        #1;
        check("reset_A", A, 32'h0);
        check("reset_B", B, 32'h0);
        tick();
        tick();
        #2 rst_n = 1'b1;

        // Write-disable: 12 clocks with WE=0 leave reg1 at zero.
        WE = 1'b0; rW = 5'd1; W = 32'hFFFFFFFF; rA = 5'd1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("we0_A_%0d", i), A, 32'h0);
        end

        // Write reg1, port B on reg2 stays zero.
        WE = 1'b1; rW = 5'd1; W = 32'hFFFFFFFF; rA = 5'd1; rB = 5'd2;
        tick();
        check("wr1_A", A, 32'hFFFFFFFF);
        check("wr1_B", B, 32'h0);

        // Write reg2, reg1 unchanged.
        rW = 5'd2; W = 32'h88888888;
        tick();
        check("wr2_B", B, 32'h88888888);
        check("wr2_A", A, 32'hFFFFFFFF);

        // R0 protection, including the cycle before each edge.
        rW = 5'd0; W = 32'h88888888; rA = 5'd0; rB = 5'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("r0_pre_A_%0d", i), A, 32'h0);
            tick();
            check($sformatf("r0_A_%0d", i), A, 32'h0);
            check($sformatf("r0_B_%0d", i), B, 32'h0);
        end

        // Same address on both ports.
        WE = 1'b0; rA = 5'd2; rB = 5'd2;
        #1;
        check("same_A", A, 32'h88888888);
        check("same_B", B, 32'h88888888);

        // Async reset mid-cycle clears immediately.
        rA = 5'd1; rB = 5'd2;
        tick();
        rst_n = 1'b0;
        #1;
        check("arst_A", A, 32'h0);
        check("arst_B", B, 32'h0);

        // Write attempted across an edge while reset is held is ignored.
        WE = 1'b1; rW = 5'd4; W = 32'hDEADBEEF;
        tick();
        WE = 1'b0;
        #2 rst_n = 1'b1;
        rA = 5'd4;
        #1;
        check("rst_wr4_A", A, 32'h0);

        // Write after release reads back.
        WE = 1'b1; rW = 5'd3; W = 32'h12345678; rA = 5'd3;
        tick();
        WE = 1'b0;
        check("wr3_A", A, 32'h12345678);

        // WE=0 with matching address never forwards W.
        rW = 5'd3; W = 32'h55555555; rB = 5'd3;
        #1;
        check("nowe_B", B, 32'h12345678);
        tick();
        check("nowe_B_post", B, 32'h12345678);

        // Collision on reg5.
        WE = 1'b1; rW = 5'd5; W = 32'h11111111;
        tick();
        WE = 1'b1; rW = 5'd5; W = 32'hAAAAAAAA; rA = 5'd5; rB = 5'd5;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_pre = 32'hAAAAAAAA;
`else
        exp_pre = 32'h11111111;
`endif
        check("coll_pre_A", A, exp_pre);
        check("coll_pre_B", B, exp_pre);
        tick();
        WE = 1'b0;
        check("coll_post_A", A, 32'hAAAAAAAA);
        check("coll_post_B", B, 32'hAAAAAAAA);

        // Earlier registers untouched by later traffic.
        rA = 5'd3; rB = 5'd1;
        #1;
        check("keep_A", A, 32'h12345678);
        check("keep_B", B, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
